// File: rtl/nano_ctrl.sv
// nano_ctrl -- two-byte-instruction accumulator controller.
//
// Fetches an opcode byte (low nibble used) and an operand-address byte,
// then either runs an ALU operation against RAM[operand], stores the
// accumulator to RAM[operand], or performs a (conditional) jump whose
// target is the operand byte itself.
//
// Ports:
//   clk        system clock, rising edge active
//   reset      asynchronous active-high reset
//   step       (NANO_STEP_EN only) single-step enable, FSM waits in F1 while low
//   ram_addr   RAM address (registered)
//   ram_rdata  RAM read data, one cycle after ram_addr
//   ram_wdata  RAM write data (accumulator)
//   ram_we     RAM write enable (registered, cleared asynchronously by reset)
//   alu_i      ALU opcode (IR)
//   alu_a      ALU operand A (accumulator)
//   alu_b      ALU operand B (ram_rdata)
//   alu_cin    ALU carry in (registered C flag)
//   alu_s      ALU result
//   alu_cout   ALU carry out
//   alu_z      ALU zero flag
//   acc        accumulator, debug
//   pc         program counter, debug
//
// Configuration macro: NANO_STEP_EN adds the step input.

module nano_ctrl (
   input  logic       clk,
   input  logic       reset,
`ifdef NANO_STEP_EN
   input  logic       step,
`endif
   output logic [7:0] ram_addr,
   input  logic [7:0] ram_rdata,
   output logic [7:0] ram_wdata,
   output logic       ram_we,
   output logic [3:0] alu_i,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_cin,
   input  logic [7:0] alu_s,
   input  logic       alu_cout,
   input  logic       alu_z,
   output logic [7:0] acc,
   output logic [7:0] pc
);

   typedef enum logic [2:0] {
      F1  = 3'd0,
      F2  = 3'd1,
      F3  = 3'd2,
      MEM = 3'd3,
      EX  = 3'd4
   } state_t;

   localparam logic [3:0] OP_LAST_ALU = 4'hB;
   localparam logic [3:0] OP_STA      = 4'hC;

   state_t     state_r, state_s;
   logic [7:0] pc_r, pc_s;
   logic [7:0] a_r, a_s;
   logic       c_r, c_s;
   logic       z_r, z_s;
   logic [3:0] ir_r, ir_s;
   logic [7:0] ar_r, ar_s;
   logic [7:0] ram_addr_r, ram_addr_s;
   logic       ram_we_r, ram_we_s;

   // Branch condition for the jump group; non-jump opcodes never take.
   function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
      logic t;
      case (op)
         4'hD:    t = 1'b1;
         4'hE:    t = c;
         4'hF:    t = z;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Next-state and architectural register updates.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      a_s     = a_r;
      c_s     = c_r;
      z_s     = z_r;
      ir_s    = ir_r;
      ar_s    = ar_r;
      case (state_r)
         F1: begin
`ifdef NANO_STEP_EN
            if (step) begin
               state_s = F2;
            end else begin
               state_s = F1;
            end
`else
            state_s = F2;
`endif
         end
         F2: begin
            ir_s    = ram_rdata[3:0];
            state_s = F3;
         end
         F3: begin
            ar_s = ram_rdata;
            if (ir_r <= OP_STA) begin
               state_s = MEM;
            end else begin
               // Jump target is the operand byte on the bus right now,
               // not the AR copy that only appears next cycle.
               if (jump_taken(ir_r, c_r, z_r)) begin
                  pc_s = ram_rdata;
               end else begin
                  pc_s = pc_r + 8'd2;
               end
               state_s = F1;
            end
         end
         MEM: begin
            if (ir_r == OP_STA) begin
               pc_s    = pc_r + 8'd2;
               state_s = F1;
            end else begin
               state_s = EX;
            end
         end
         EX: begin
            a_s     = alu_s;
            c_s     = alu_cout;
            z_s     = alu_z;
            pc_s    = pc_r + 8'd2;
            state_s = F1;
         end
         default: begin
            state_s = F1;
         end
      endcase
   end

   // RAM address and write enable for the cycle about to start, so both
   // leave the block straight from flops.
   always_comb begin
      ram_addr_s = pc_s;
      ram_we_s   = 1'b0;
      case (state_s)
         F1: begin
            ram_addr_s = pc_s;
         end
         F2, F3: begin
            ram_addr_s = pc_s + 8'd1;
         end
         MEM: begin
            ram_addr_s = ar_s;
            ram_we_s   = (ir_s == OP_STA) && (ir_s > OP_LAST_ALU);
         end
         EX: begin
            ram_addr_s = ar_s;
         end
         default: begin
            ram_addr_s = pc_s;
         end
      endcase
   end

   // State and datapath registers; reset also drops ram_we at once so an
   // interrupted store never reaches the RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= F1;
         pc_r       <= 8'h00;
         a_r        <= 8'h00;
         c_r        <= 1'b0;
         z_r        <= 1'b0;
         ir_r       <= 4'h0;
         ar_r       <= 8'h00;
         ram_addr_r <= 8'h00;
         ram_we_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         a_r        <= a_s;
         c_r        <= c_s;
         z_r        <= z_s;
         ir_r       <= ir_s;
         ar_r       <= ar_s;
         ram_addr_r <= ram_addr_s;
         ram_we_r   <= ram_we_s;
      end
   end

   assign ram_addr  = ram_addr_r;
   assign ram_we    = ram_we_r;
   assign ram_wdata = a_r;
   assign alu_i     = ir_r;
   assign alu_a     = a_r;
   assign alu_b     = ram_rdata;
   assign alu_cin   = c_r;
   assign acc       = a_r;
   assign pc        = pc_r;

endmodule

// File: tb/tb_nano_ctrl.sv
// tb_nano_ctrl -- bench for nano_ctrl with a synchronous RAM, a simple
// adder ALU (opcode 0x2 adds carry-in, all other ALU opcodes plain add),
// an instruction-level reference model producing expected bus traces,
// and directed literal checks on hand-computed values.

module tb_nano_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] ram_addr, ram_rdata, ram_wdata;
   logic       ram_we;
   logic [3:0] alu_i;
   logic [7:0] alu_a, alu_b, alu_s, acc, pc;
   logic       alu_cin, alu_cout, alu_z;
`ifdef NANO_STEP_EN
   logic       step;
   assign step = 1'b1;
`endif

   always #5 clk = ~clk;

   nano_ctrl dut (
      .clk(clk),
      .reset(reset),
`ifdef NANO_STEP_EN
      .step(step),
`endif
      .ram_addr(ram_addr),
      .ram_rdata(ram_rdata),
      .ram_wdata(ram_wdata),
      .ram_we(ram_we),
      .alu_i(alu_i),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_cin(alu_cin),
      .alu_s(alu_s),
      .alu_cout(alu_cout),
      .alu_z(alu_z),
      .acc(acc),
      .pc(pc)
   );

   // Environment: synchronous RAM and combinational ALU.
   logic [7:0] mem [0:255];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   logic [8:0] alu_sum;
   assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, (alu_i == 4'h2) ? alu_cin : 1'b0};
   assign alu_s    = alu_sum[7:0];
   assign alu_cout = alu_sum[8];
   assign alu_z    = (alu_sum[7:0] == 8'h00);

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level reference model -----------------------------------
   typedef struct {
      logic       chk_addr;
      logic [7:0] addr;
      logic       we;
      logic [7:0] wdata;
      logic       arch;
      logic [7:0] pc;
      logic [7:0] acc;
      logic       cin;
      logic       z;
      logic       alu;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   exp_t       expq[$];
   exp_t       ce;
   logic [7:0] model_mem [0:255];
   logic [7:0] m_pc, m_a;
   logic       m_c, m_z;
   logic       pend_v;
   logic [7:0] pend_addr, pend_data;

   function automatic exp_t blank();
      exp_t e;
      e.chk_addr = 1'b1; e.addr = 8'h00; e.we = 1'b0; e.wdata = 8'h00;
      e.arch = 1'b0; e.pc = 8'h00; e.acc = 8'h00; e.cin = 1'b0; e.z = 1'b0;
      e.alu = 1'b0; e.op = 4'h0; e.a = 8'h00; e.b = 8'h00;
      return e;
   endfunction

   // Expands the instruction at m_pc into its per-cycle bus trace and
   // advances the architectural state.
   function automatic void model_step();
      exp_t       e;
      logic [7:0] nxt, opd, b;
      logic [3:0] op;
      logic [8:0] sum;
      logic       taken;
      nxt = m_pc + 8'd1;
      op  = model_mem[m_pc][3:0];
      opd = model_mem[nxt];
      e = blank(); e.addr = m_pc; e.arch = 1'b1; e.pc = m_pc; e.acc = m_a; e.cin = m_c; e.z = m_z;
      expq.push_back(e);
      e = blank(); e.addr = nxt;
      expq.push_back(e);
      e = blank(); e.chk_addr = 1'b0;
      expq.push_back(e);
      if (op <= 4'hB) begin
         b = model_mem[opd];
         e = blank(); e.addr = opd;
         expq.push_back(e);
         e = blank(); e.addr = opd; e.alu = 1'b1; e.op = op; e.a = m_a; e.b = b; e.cin = m_c;
         expq.push_back(e);
         sum  = {1'b0, m_a} + {1'b0, b} + (((op == 4'h2) && m_c) ? 9'd1 : 9'd0);
         m_a  = sum[7:0];
         m_c  = sum[8];
         m_z  = (sum[7:0] == 8'h00);
         m_pc = m_pc + 8'd2;
      end else if (op == 4'hC) begin
         e = blank(); e.addr = opd; e.we = 1'b1; e.wdata = m_a;
         expq.push_back(e);
         m_pc = m_pc + 8'd2;
      end else begin
         taken = (op == 4'hD) || ((op == 4'hE) && m_c) || ((op == 4'hF) && m_z);
         m_pc  = taken ? opd : m_pc + 8'd2;
      end
   endfunction

   // Per-cycle compare of DUT outputs against the model trace.
   always @(negedge clk) begin
      if (reset) begin
         expq.delete();
         m_pc = 8'h00; m_a = 8'h00; m_c = 1'b0; m_z = 1'b0; pend_v = 1'b0;
      end else begin
         if (pend_v) begin
            model_mem[pend_addr] = pend_data;
            pend_v = 1'b0;
         end
         if (expq.size() == 0) model_step();
         ce = expq.pop_front();
         if (ce.chk_addr) chk("model ram_addr", 32'(ram_addr), 32'(ce.addr));
         chk("model ram_we", 32'(ram_we), 32'(ce.we));
         if (ce.we) begin
            chk("model ram_wdata", 32'(ram_wdata), 32'(ce.wdata));
            pend_v = 1'b1; pend_addr = ce.addr; pend_data = ce.wdata;
         end
         if (ce.arch) begin
            chk("model pc", 32'(pc), 32'(ce.pc));
            chk("model acc", 32'(acc), 32'(ce.acc));
            chk("model C", 32'(alu_cin), 32'(ce.cin));
            chk("model Z", 32'(dut.z_r), 32'(ce.z));
         end
         if (ce.alu) begin
            chk("model alu_i", 32'(alu_i), 32'(ce.op));
            chk("model alu_a", 32'(alu_a), 32'(ce.a));
            chk("model alu_b", 32'(alu_b), 32'(ce.b));
            chk("model alu_cin", 32'(alu_cin), 32'(ce.cin));
         end
      end
   end

   // Directed scenarios ---------------------------------------------------
   int cyc = 0;

   task automatic begin_prog();
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00;
         model_mem[i] = 8'h00;
      end
   endtask

   task automatic put(input logic [7:0] a, input logic [7:0] d);
      mem[a] = d;
      model_mem[a] = d;
   endtask

   task automatic go();
      @(posedge clk);
      #1 reset = 1'b0;
      cyc = 0;
   endtask

   task automatic nxt();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) nxt();
   endtask

   int         we_n;
   logic [7:0] we_a, we_d;

   initial begin
      // Scenario A: reset state, ALU add, JZ both ways, ADC carry chain, JCS.
      begin_prog();
      put(8'h00, 8'h01); put(8'h01, 8'h10); put(8'h10, 8'h05);
      put(8'h02, 8'h0F); put(8'h03, 8'h40);
      put(8'h04, 8'h01); put(8'h05, 8'h12); put(8'h12, 8'hFB);
      put(8'h06, 8'h0F); put(8'h07, 8'h40);
      put(8'h40, 8'h02); put(8'h41, 8'h13); put(8'h13, 8'h01);
      put(8'h42, 8'h0E); put(8'h43, 8'h50);
      put(8'h44, 8'h0D); put(8'h45, 8'h44);
      go();
      run_to(1);
      chk("reset ram_addr", 32'(ram_addr), 32'h00);
      chk("reset ram_we", 32'(ram_we), 32'h0);
      chk("reset pc", 32'(pc), 32'h00);
      chk("reset acc", 32'(acc), 32'h00);
      chk("reset C", 32'(alu_cin), 32'h0);
      chk("reset Z", 32'(dut.z_r), 32'h0);
      run_to(6);
      chk("add acc", 32'(acc), 32'h05);
      chk("add pc", 32'(pc), 32'h02);
      chk("add Z", 32'(dut.z_r), 32'h0);
      run_to(8);
      chk("jz nt pc during", 32'(pc), 32'h02);
      run_to(9);
      chk("jz nt pc", 32'(pc), 32'h04);
      chk("jz nt fetch", 32'(ram_addr), 32'h04);
      run_to(14);
      chk("add zero acc", 32'(acc), 32'h00);
      chk("add zero C", 32'(alu_cin), 32'h1);
      chk("add zero Z", 32'(dut.z_r), 32'h1);
      chk("add zero pc", 32'(pc), 32'h06);
      run_to(16);
      chk("jz t pc during", 32'(pc), 32'h06);
      run_to(17);
      chk("jz t pc", 32'(pc), 32'h40);
      chk("jz t fetch", 32'(ram_addr), 32'h40);
      run_to(22);
      chk("adc acc", 32'(acc), 32'h02);
      chk("adc C", 32'(alu_cin), 32'h0);
      chk("adc pc", 32'(pc), 32'h42);
      run_to(25);
      chk("jcs nt pc", 32'(pc), 32'h44);
      run_to(32);

      // Scenario B: STA, then reset in MEM of a second STA.
      begin_prog();
      put(8'h00, 8'h01); put(8'h01, 8'h10); put(8'h10, 8'h5A);
      put(8'h02, 8'h0C); put(8'h03, 8'h20);
      put(8'h04, 8'h0C); put(8'h05, 8'h21);
      put(8'h06, 8'h0D); put(8'h07, 8'h06);
      go();
      we_n = 0; we_a = 8'h00; we_d = 8'h00;
      for (int i = 0; i < 10; i++) begin
         nxt();
         if (ram_we) begin
            we_n++; we_a = ram_addr; we_d = ram_wdata;
         end
         if (cyc == 6) begin
            chk("sta pre acc", 32'(acc), 32'h5A);
            chk("sta pre pc", 32'(pc), 32'h02);
         end
      end
      chk("sta we count", 32'(we_n), 32'd1);
      chk("sta we addr", 32'(we_a), 32'h20);
      chk("sta we data", 32'(we_d), 32'h5A);
      chk("sta pc", 32'(pc), 32'h04);
      chk("sta ram", 32'(mem[8'h20]), 32'h5A);
      run_to(13);
      chk("sta2 mem we", 32'(ram_we), 32'h1);
      chk("sta2 mem addr", 32'(ram_addr), 32'h21);
      #1 reset = 1'b1;
      #1;
      chk("rst mid we", 32'(ram_we), 32'h0);
      chk("rst mid pc", 32'(pc), 32'h00);
      chk("rst mid acc", 32'(acc), 32'h00);
      chk("rst mid addr", 32'(ram_addr), 32'h00);
      nxt();
      nxt();
      chk("rst mid no write", 32'(mem[8'h21]), 32'h00);
      go();
      nxt();
      chk("rst rel F1 addr", 32'(ram_addr), 32'h00);
      nxt();
      chk("rst rel F2 addr", 32'(ram_addr), 32'h01);
      run_to(12);

      // Scenario C: JMP at 0xFE and an instruction straddling 0xFF/0x00.
      begin_prog();
      put(8'h00, 8'h0D); put(8'h01, 8'hFE);
      put(8'hFE, 8'h0D); put(8'hFF, 8'h07);
      put(8'h07, 8'h0D); put(8'h08, 8'hFF);
      put(8'h0D, 8'h33);
      go();
      run_to(4);
      chk("jmp pc FE", 32'(pc), 32'hFE);
      run_to(5);
      chk("FE byte1 addr", 32'(ram_addr), 32'hFF);
      run_to(6);
      chk("jmp FE during", 32'(pc), 32'hFE);
      run_to(7);
      chk("jmp FE target", 32'(pc), 32'h07);
      run_to(10);
      chk("jmp pc FF", 32'(pc), 32'hFF);
      run_to(11);
      chk("FF byte1 wrap", 32'(ram_addr), 32'h00);
      run_to(15);
      chk("FF next pc", 32'(pc), 32'h01);
      chk("FF acc", 32'(acc), 32'h33);
      run_to(25);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
